// File: rtl/at_reduce_pipe_pkg.sv
// Shared types and elaboration-time helpers for the AT reduction pipe.
// Contents:
//   at_mode_e    - reduction operator carried with every beat
//   AT_TAG_*     - layout of the per-beat side tag (frame-first / frame-last)
//   clog2        - ceiling log2 used to size the tree depth
//   lvl_width    - lane width at the output of tree level k
//   lvl_out_off  - bit offset of level k's output inside the packed tree bus
package at_pkg;

  typedef enum logic [1:0] {
    AT_SUM = 2'd0,
    AT_MAX = 2'd1,
    AT_MIN = 2'd2,
    AT_RSV = 2'd3
  } at_mode_e;

  localparam int AT_TAG_W     = 32'd2;
  localparam int AT_TAG_LAST  = 32'd0;
  localparam int AT_TAG_FIRST = 32'd1;

  function automatic int clog2(input int value);
    int r;
    r = 32'd0;
    for (int i = 32'd0; i < 32'd31; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 32'd1;
      end
    end
    return r;
  endfunction

  // Level k combines lanes of width dw+k into lanes one bit wider.
  function automatic int lvl_width(input int dw, input int k);
    return dw + k + 32'd1;
  endfunction

  // Levels are packed back to back, level 0 output at the bottom.
  function automatic int lvl_out_off(input int lanes, input int dw, input int k);
    int off;
    off = 32'd0;
    for (int j = 32'd0; j < k; j++) begin
      off = off + (lanes >> (j + 32'd1)) * lvl_width(dw, j);
    end
    return off;
  endfunction

endpackage

// File: rtl/at_reduce_pipe_tree.sv
// One registered level of the reduction tree.
// Combines N lanes of IW bits pairwise into N/2 lanes of IW+1 bits (SUM keeps the
// carry, MAX/MIN results are zero-extended). Valid, mode and the frame tag travel
// alongside the data. All registers hold while en is low.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  pipe advance enable (low = stall)
//   din_valid/mode/tag  beat qualifiers entering the level
//   din                 N packed lanes of IW bits
//   dout_valid/mode/tag registered qualifiers
//   dout                N/2 packed lanes of IW+1 bits
module at_tree_level
  import at_pkg::*;
#(
  parameter int N  = 16,
  parameter int IW = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      din_valid,
  input  at_mode_e                  din_mode,
  input  logic [AT_TAG_W-1:0]       din_tag,
  input  logic [N*IW-1:0]           din,
  output logic                      dout_valid,
  output at_mode_e                  dout_mode,
  output logic [AT_TAG_W-1:0]       dout_tag,
  output logic [(N/2)*(IW+1)-1:0]   dout
);

  localparam int OWL = IW + 32'd1;
  localparam int NO  = N / 32'd2;

  logic [NO*OWL-1:0] comb_s;
  logic [IW-1:0]     a_s;
  logic [IW-1:0]     b_s;

  // Pairwise combine of neighbouring lanes according to the beat's operator
  always_comb begin
    comb_s = '0;
    a_s    = '0;
    b_s    = '0;
    for (int j = 32'd0; j < NO; j++) begin
      a_s = din[(32'd2*j)*IW +: IW];
      b_s = din[(32'd2*j+32'd1)*IW +: IW];
      case (din_mode)
        AT_MAX:  comb_s[j*OWL +: OWL] = (a_s > b_s) ? {1'b0, a_s} : {1'b0, b_s};
        AT_MIN:  comb_s[j*OWL +: OWL] = (a_s < b_s) ? {1'b0, a_s} : {1'b0, b_s};
        default: comb_s[j*OWL +: OWL] = {1'b0, a_s} + {1'b0, b_s};
      endcase
    end
  end

  // Level register; holds everything during a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_mode  <= AT_SUM;
      dout_tag   <= '0;
      dout       <= '0;
    end else if (en) begin
      dout_valid <= din_valid;
      dout_mode  <= din_mode;
      dout_tag   <= din_tag;
      dout       <= comb_s;
    end
  end

endmodule

// File: rtl/at_reduce_pipe.sv
// Pipelined AT reduction core: reduces LANES lanes of DW bits per beat with
// SUM/MAX/MIN through a clog2(LANES)-deep registered tree, then accumulates the
// per-beat results over a frame and presents one result per frame.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake (in_ready = no held, unconsumed result)
//   A                    packed lanes, lane i = A[i*DW +: DW]
//   in_last              beat closes the frame
//   in_mode              operator, sampled on the first beat of a frame only
//   out_valid/out_ready  result handshake
//   out_data             frame result (SUM saturates at 2^OW-1)
//   out_sat              SUM result was clipped somewhere in the frame
module at_reduce_pipe
  import at_pkg::*;
#(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int OW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*DW-1:0]  A,
  input  logic                 in_last,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        out_data,
  output logic                 out_sat
);

  localparam int LVL   = clog2(LANES);
  localparam int RW    = DW + LVL;
  localparam int BUS_W = lvl_out_off(LANES, DW, LVL);

  typedef enum logic {ST_IDLE = 1'b0, ST_IN_FRAME = 1'b1} frame_state_e;

  frame_state_e          state_r;
  frame_state_e          state_next_s;
  at_mode_e              frame_mode_r;
  logic                  accept_s;
  logic                  first_s;
  at_mode_e              beat_mode_s;

  logic [BUS_W-1:0]      tree_bus_s;
  logic                  stage_valid_s [LVL+1];
  at_mode_e              stage_mode_s  [LVL+1];
  logic [AT_TAG_W-1:0]   stage_tag_s   [LVL+1];

  logic [RW-1:0]         tree_res_s;
  logic                  t_valid_s;
  logic                  t_first_s;
  logic                  t_last_s;
  at_mode_e              t_mode_s;

  logic [OW-1:0]         acc_r;
  logic                  sat_r;
  logic [OW-1:0]         r_ext_s;
  logic [OW:0]           sum_s;
  logic [OW-1:0]         comb_s;
  logic                  clip_s;
  logic                  sat_next_s;

  // A result the consumer has not taken freezes the whole pipe.
  assign in_ready = ~(out_valid & ~out_ready);
  assign accept_s = in_valid & in_ready;
  assign first_s  = (state_r == ST_IDLE);

  // Later beats inherit the operator latched on the frame's first beat.
  assign beat_mode_s      = first_s ? at_mode_e'(in_mode) : frame_mode_r;
  assign stage_valid_s[0] = accept_s;
  assign stage_mode_s[0]  = beat_mode_s;
  assign stage_tag_s[0]   = {first_s, in_last};

  // Frame FSM next-state: any accepted beat decides whether a frame stays open
  always_comb begin
    state_next_s = state_r;
    if (accept_s) begin
      if (in_last) begin
        state_next_s = ST_IDLE;
      end else begin
        state_next_s = ST_IN_FRAME;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // Frame FSM state and latched frame operator
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      frame_mode_r <= AT_SUM;
    end else begin
      state_r <= state_next_s;
      if (accept_s && first_s) begin
        frame_mode_r <= beat_mode_s;
      end
    end
  end

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int NK  = LANES >> k;
    localparam int IWK = DW + k;
    logic [NK*IWK-1:0] din_s;

    if (k == 0) begin : g_src
      assign din_s = A;
    end else begin : g_src
      assign din_s = tree_bus_s[lvl_out_off(LANES, DW, k - 1) +: NK*IWK];
    end

    at_tree_level #(
      .N  (NK),
      .IW (IWK)
    ) u_level (
      .clk        (clk),
      .rst        (rst),
      .en         (in_ready),
      .din_valid  (stage_valid_s[k]),
      .din_mode   (stage_mode_s[k]),
      .din_tag    (stage_tag_s[k]),
      .din        (din_s),
      .dout_valid (stage_valid_s[k+1]),
      .dout_mode  (stage_mode_s[k+1]),
      .dout_tag   (stage_tag_s[k+1]),
      .dout       (tree_bus_s[lvl_out_off(LANES, DW, k) +: (NK/2)*(IWK+1)])
    );
  end

  // The final level is a single lane sitting at the top of the bus.
  assign tree_res_s = tree_bus_s[BUS_W-1 -: RW];
  assign t_valid_s  = stage_valid_s[LVL];
  assign t_mode_s   = stage_mode_s[LVL];
  assign t_first_s  = stage_tag_s[LVL][AT_TAG_FIRST];
  assign t_last_s   = stage_tag_s[LVL][AT_TAG_LAST];

  // Accumulator combine: first beat loads, later beats fold in with clipping SUM
  always_comb begin
    r_ext_s    = OW'(tree_res_s);
    sum_s      = {1'b0, acc_r} + {1'b0, r_ext_s};
    comb_s     = r_ext_s;
    clip_s     = 1'b0;
    if (t_first_s) begin
      comb_s = r_ext_s;
      clip_s = 1'b0;
    end else begin
      case (t_mode_s)
        AT_MAX: begin
          comb_s = (acc_r > r_ext_s) ? acc_r : r_ext_s;
          clip_s = 1'b0;
        end
        AT_MIN: begin
          comb_s = (acc_r < r_ext_s) ? acc_r : r_ext_s;
          clip_s = 1'b0;
        end
        default: begin
          if (sum_s[OW]) begin
            comb_s = '1;
            clip_s = 1'b1;
          end else begin
            comb_s = sum_s[OW-1:0];
            clip_s = 1'b0;
          end
        end
      endcase
    end
    sat_next_s = (~t_first_s & sat_r) | clip_s;
  end

  // Accumulator and output register; a closing beat publishes and clears the accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= '0;
      sat_r     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (in_ready) begin
      if (t_valid_s && t_last_s) begin
        out_data  <= comb_s;
        out_sat   <= sat_next_s;
        out_valid <= 1'b1;
        acc_r     <= '0;
        sat_r     <= 1'b0;
      end else if (t_valid_s) begin
        acc_r     <= comb_s;
        sat_r     <= sat_next_s;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_at_reduce_pipe.sv
// Self-checking bench for at_reduce_pipe (LANES=16, DW=8, OW=16).
// A frame-level reference model turns every accepted beat into an expected
// {sat,data} result; a monitor compares each delivered result in order.
module tb_at_reduce_pipe;

  localparam int LANES = 16;
  localparam int DW    = 8;
  localparam int OW    = 16;
  localparam longint SAT_MAX = 65535;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*DW-1:0] a_bus = '0;
  logic                in_last = 1'b0;
  logic [1:0]          in_mode = 2'd0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [OW-1:0]       out_data;
  logic                out_sat;

  int checks   = 0;
  int failures = 0;
  int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random

  logic [OW:0] exp_q[$];
  bit          fr_active = 1'b0;
  int          fr_mode   = 0;
  longint      fr_acc    = 0;

  always #5 clk = ~clk;

  at_reduce_pipe #(.LANES(LANES), .DW(DW), .OW(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_bus),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint reduce_beat(input logic [LANES*DW-1:0] a, input int mode);
    longint r;
    longint l;
    r = (mode == 2) ? 255 : 0;
    for (int i = 0; i < LANES; i++) begin
      l = longint'(a[i*DW +: DW]);
      if (mode == 1) begin
        if (l > r) r = l;
      end else if (mode == 2) begin
        if (l < r) r = l;
      end else begin
        r = r + l;
      end
    end
    return r;
  endfunction

  // Frame-level model: unbounded SUM clipped once at the end (clipping is monotonic).
  task automatic model_beat(input logic [LANES*DW-1:0] a, input logic last, input int mode);
    longint r;
    logic [OW:0] e;
    bit first;
    first = !fr_active;
    if (first) begin
      fr_mode   = mode;
      fr_active = 1'b1;
    end
    r = reduce_beat(a, fr_mode);
    if (first) fr_acc = r;
    else if (fr_mode == 1) fr_acc = (r > fr_acc) ? r : fr_acc;
    else if (fr_mode == 2) fr_acc = (r < fr_acc) ? r : fr_acc;
    else fr_acc = fr_acc + r;
    if (last) begin
      if (fr_mode != 1 && fr_mode != 2 && fr_acc > SAT_MAX) e = {1'b1, 16'hFFFF};
      else e = {1'b0, fr_acc[OW-1:0]};
      exp_q.push_back(e);
      fr_active = 1'b0;
    end
  endtask

  task automatic send_beat(input logic [LANES*DW-1:0] a, input logic last, input int mode);
    bit took;
    int guard;
    took  = 1'b0;
    guard = 0;
    a_bus    = a;
    in_last  = last;
    in_mode  = mode[1:0];
    in_valid = 1'b1;
    while (!took && guard < 300) begin
      @(negedge clk);
      took = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (took) begin
      model_beat(a, last, mode);
    end else begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept_within_300");
    end
  endtask

  function automatic logic [LANES*DW-1:0] fill(input logic [DW-1:0] v);
    logic [LANES*DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Consumer-side ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Result monitor: every transfer is checked against the model queue in order
  always @(negedge clk) begin
    logic [OW:0] e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_result observed=%0h expected=none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("result", {out_sat, out_data}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LANES*DW-1:0] a;
    int lat;
    int len;
    int md;
    bit hi;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 1: single-beat SUM and latency
    send_beat(fill(8'h01), 1'b1, 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 5);
    wait_drain();

    // 2: MAX/MIN of lane i = 3*i, plus extreme lanes
    for (int i = 0; i < LANES; i++) a[i*DW +: DW] = 8'(3 * i);
    send_beat(a, 1'b1, 1);
    send_beat(a, 1'b1, 2);
    send_beat(fill(8'h00), 1'b1, 1);
    send_beat(fill(8'hFF), 1'b1, 2);
    send_beat(fill(8'h07), 1'b1, 3);
    wait_drain();

    // 3: saturation, sticky through a zero beat, then a clean frame
    for (int b = 0; b < 20; b++) send_beat(fill(8'hFF), b == 19, 0);
    send_beat(fill(8'h01), 1'b1, 0);
    for (int b = 0; b < 17; b++) send_beat(fill(8'hFF), 1'b0, 0);
    send_beat(fill(8'h00), 1'b1, 0);
    wait_drain();

    // 4: backpressure with 8 back-to-back single-beat frames
    ready_mode = 1;
    @(posedge clk);
    #2;
    fork
      begin
        for (int k = 1; k <= 8; k++) send_beat(fill(8'(k)), 1'b1, 0);
      end
      begin
        repeat (9) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_data", out_data, 16'h0010);
        repeat (1) @(negedge clk);
        ready_mode = 0;
      end
    join
    wait_drain();

    // 5: mode latched on first beat
    send_beat(fill(8'h10), 1'b0, 1);
    send_beat(fill(8'h20), 1'b1, 2);
    wait_drain();

    // 6: reset mid-frame discards the partial frame
    send_beat(fill(8'h05), 1'b0, 0);
    send_beat(fill(8'h05), 1'b0, 0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fr_active = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    send_beat(fill(8'h02), 1'b1, 0);
    wait_drain();
    send_beat(fill(8'h03), 1'b0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fr_active = 1'b0;
    send_beat(fill(8'h02), 1'b1, 1);
    wait_drain();

    // Randomized frames with random consumer stalls
    ready_mode = 2;
    for (int f = 0; f < 30; f++) begin
      len = (f % 5 == 0) ? $urandom_range(15, 22) : $urandom_range(1, 6);
      md  = $urandom_range(0, 3);
      hi  = ($urandom_range(0, 1) == 1);
      for (int b = 0; b < len; b++) begin
        for (int i = 0; i < LANES; i++) begin
          a[i*DW +: DW] = hi ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
        end
        send_beat(a, b == len - 1, (b == 0) ? md : $urandom_range(0, 3));
      end
    end
    ready_mode = 0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
